// File: rtl/ysyx_22051013_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051013_lsu_pkg
// Description : Shared definitions for the LSU: lsu_op field positions,
//               access-size and FSM state encodings, byte-strobe helper and
//               the core-wide data/PC width macros.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef ysyx_22051013_DATA
`define ysyx_22051013_DATA 64
`endif
`ifndef ysyx_22051013_PC
`define ysyx_22051013_PC 64
`endif

package ysyx_22051013_lsu_pkg;

  // lsu_op field positions
  localparam int c_op_store_bit    = 3;
  localparam int c_op_unsigned_bit = 2;

  // Access size, lsu_op[1:0]
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } lsu_state_e;

  // Byte strobes for an access of the given size at byte offset off.
  // Bits shifted past lane 7 are dropped.
  function automatic logic [7:0] lsu_wstrb(input lsu_size_e size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22051013_lsu_ext.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051013_lsu_ext
// Description : Combinational load alignment: shifts the raw 64-bit read
//               word down by the byte offset, truncates to the access size
//               and sign- or zero-extends.
// Ports       : rdata       - raw read word
//               off         - byte offset within the word
//               size        - access size
//               is_unsigned - zero-extend instead of sign-extend (ignored for D)
//               result      - extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051013_lsu_ext
  import ysyx_22051013_lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        off,
  input  lsu_size_e         size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    result  = shifted;
    case (size)
      SZ_B: result = is_unsigned ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                 : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      SZ_H: result = is_unsigned ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                 : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      SZ_W: result = is_unsigned ? {{(DATA_W-32){1'b0}}, shifted[31:0]}
                                 : {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22051013_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051013_lsu
// Description : Memory-access stage. Accepts a load/store from EXU, runs one
//               outstanding request on a valid/ready memory port, and returns
//               the aligned, extended load result registered on ls_rd_data.
//               ls_valid is the busy flag that stalls the pipeline.
// Ports       : clk, rst (sync, active-high)
//               lsu_en/lsu_op/lsu_addr/lsu_wdata - command from EXU
//               flush                            - pipeline flush from WBU
//               mem_req_*                        - request channel
//               mem_rsp_valid/mem_rsp_rdata      - response channel
//               ls_rd_data, ls_valid             - to WBU / hazard logic
//               lsu_misalign                     - only with macro below
// Config      : YSYX_22051013_LSU_MISALIGN_CHECK_EN - when defined, misaligned
//               accesses are trapped locally (no bus request, one-cycle
//               lsu_misalign pulse, ls_rd_data cleared).
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051013_lsu
  import ysyx_22051013_lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_en,
  input  logic [3:0]        lsu_op,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic [DATA_W-1:0] ls_rd_data,
  output logic              ls_valid
`ifdef YSYX_22051013_LSU_MISALIGN_CHECK_EN
  ,
  output logic              lsu_misalign
`endif
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              discard_q, discard_d;

  logic [2:0]        in_off;
  lsu_size_e         in_size;
  logic              in_misalign;
  logic [DATA_W-1:0] ext_result;

  assign in_off  = lsu_addr[2:0];
  assign in_size = lsu_size_e'(lsu_op[1:0]);

`ifdef YSYX_22051013_LSU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign in_misalign = ((in_size == SZ_H) && in_off[0])
                     | ((in_size == SZ_W) && (in_off[1:0] != 2'b00))
                     | ((in_size == SZ_D) && (in_off != 3'b000));
  assign lsu_misalign = misalign_q;
`else
  assign in_misalign = 1'b0;
`endif

  ysyx_22051013_lsu_ext #(
    .DATA_W (DATA_W)
  ) u_ext (
    .rdata       (mem_rsp_rdata),
    .off         (addr_q[2:0]),
    .size        (lsu_size_e'(op_q[1:0])),
    .is_unsigned (op_q[c_op_unsigned_bit]),
    .result      (ext_result)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_data_d = rd_data_q;
    discard_d = discard_q;
`ifdef YSYX_22051013_LSU_MISALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lsu_en && !flush) begin
          if (in_misalign) begin
            rd_data_d = '0;
`ifdef YSYX_22051013_LSU_MISALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            addr_d    = lsu_addr;
            op_d      = lsu_op;
            wdata_d   = lsu_wdata << {in_off, 3'b000};
            wstrb_d   = lsu_wstrb(in_size, in_off);
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          // A flush coinciding with acceptance cannot recall the request;
          // the response is still awaited but its data is dropped.
          state_d   = ST_RSP;
          discard_d = flush;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_RSP: begin
        if (flush) begin
          discard_d = 1'b1;
        end
        if (mem_rsp_valid) begin
          state_d = ST_IDLE;
          if (!op_q[c_op_store_bit] && !discard_q && !flush) begin
            rd_data_d = ext_result;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_data_q <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rd_data_q <= rd_data_d;
      discard_q <= discard_d;
    end
  end

`ifdef YSYX_22051013_LSU_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_req_wen   = op_q[c_op_store_bit];
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign ls_rd_data    = rd_data_q;

  // Busy drops in the response cycle so the WBU sees fresh ls_rd_data the
  // cycle the instruction arrives; forced low while reset is asserted.
  assign ls_valid = !rst && (((state_q == ST_IDLE) && lsu_en && !flush && !in_misalign)
                          || (state_q == ST_REQ)
                          || ((state_q == ST_RSP) && !mem_rsp_valid));

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22051013_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22051013_lsu
// Description : Directed self-checking bench for ysyx_22051013_lsu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051013_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_en;
  logic [3:0]  lsu_op;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic [63:0] ls_rd_data;
  logic        ls_valid;
`ifdef YSYX_22051013_LSU_MISALIGN_CHECK_EN
  logic        lsu_misalign;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_rd;

  ysyx_22051013_lsu #(
    .ADDR_W (64),
    .DATA_W (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lsu_en        (lsu_en),
    .lsu_op        (lsu_op),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .ls_rd_data    (ls_rd_data),
    .ls_valid      (ls_valid)
`ifdef YSYX_22051013_LSU_MISALIGN_CHECK_EN
    ,
    .lsu_misalign  (lsu_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // Advance one cycle; inputs are then changed 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: enable cycle, rdy_dly cycles of ready low, accept,
  // rsp_dly cycles of response wait, response cycle. lsu_en is held high
  // with unrelated garbage while busy to show it is ignored.
  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [63:0] rd,
                        input int rdy_dly, input int rsp_dly,
                        input logic [63:0] e_addr, input logic [63:0] e_wdata,
                        input logic [7:0] e_wstrb, input logic e_wen);
    lsu_en = 1'b1; lsu_op = op; lsu_addr = addr; lsu_wdata = wd;
    #1;
    check({name, "_busy_en"}, 64'(ls_valid), 64'd1);
    tick();
    lsu_op = 4'b1011; lsu_addr = 64'h0000_0000_DEAD_0008; lsu_wdata = '1;
    for (int i = 0; i <= rdy_dly; i++) begin
      mem_req_ready = (i == rdy_dly);
      #1;
      check({name, "_req_valid"}, 64'(mem_req_valid), 64'd1);
      check({name, "_req_addr"},  mem_req_addr, e_addr);
      check({name, "_req_wdata"}, mem_req_wdata, e_wdata);
      check({name, "_req_wstrb"}, 64'(mem_req_wstrb), 64'(e_wstrb));
      check({name, "_req_wen"},   64'(mem_req_wen), 64'(e_wen));
      check({name, "_busy_req"},  64'(ls_valid), 64'd1);
      tick();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      #1;
      check({name, "_rsp_wait_valid"}, 64'(mem_req_valid), 64'd0);
      check({name, "_busy_rsp_wait"},  64'(ls_valid), 64'd1);
      tick();
    end
    lsu_en = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rd;
    #1;
    check({name, "_busy_rsp"}, 64'(ls_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    #1;
    check({name, "_rd_data"},   ls_rd_data, exp_rd);
    check({name, "_idle_valid"}, 64'(mem_req_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; lsu_en = 1'b0; lsu_op = '0; lsu_addr = '0; lsu_wdata = '0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    tick();
    lsu_en = 1'b1; lsu_addr = 64'h8000_0000;
    #1;
    check("rst_busy", 64'(ls_valid), 64'd0);
    tick();
    lsu_en = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_wen",   64'(mem_req_wen), 64'd0);
    check("rst_req_addr",  mem_req_addr, 64'd0);
    check("rst_req_wdata", mem_req_wdata, 64'd0);
    check("rst_req_wstrb", 64'(mem_req_wstrb), 64'd0);
    check("rst_rd_data",   ls_rd_data, 64'd0);
    check("rst_busy_idle", 64'(ls_valid), 64'd0);

    // lb signed / lbu at offset 3
    exp_rd = 64'hFFFF_FFFF_FFFF_FF80;
    run_op("lb", 4'b0000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0,
           64'h8000_0000, 64'd0, 8'h08, 1'b0);
    // sh at offset 6; store leaves ls_rd_data alone
    run_op("sh", 4'b1001, 64'h8000_0006, 64'h1234, 64'hFFFF_0000_FFFF_0000, 0, 0,
           64'h8000_0000, 64'h1234_0000_0000_0000, 8'hC0, 1'b1);
    exp_rd = 64'h80;
    run_op("lbu", 4'b0100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0,
           64'h8000_0000, 64'd0, 8'h08, 1'b0);
    // ld with ready held off 5 cycles and response 3 cycles late
    exp_rd = 64'h0123_4567_89AB_CDEF;
    run_op("ld", 4'b0011, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 5, 3,
           64'h8000_0010, 64'd0, 8'hFF, 1'b0);
    exp_rd = 64'hFFFF_FFFF_FFFF_F00D;
    run_op("lh", 4'b0001, 64'h8000_0022, 64'd0, 64'h0000_0000_F00D_0000, 0, 1,
           64'h8000_0020, 64'd0, 8'h0C, 1'b0);
    exp_rd = 64'h0000_0000_8765_4321;
    run_op("lwu", 4'b0110, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 1, 0,
           64'h8000_0000, 64'd0, 8'hF0, 1'b0);
    exp_rd = 64'hFFFF_FFFF_8765_4321;
    run_op("lw", 4'b0010, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 0,
           64'h8000_0000, 64'd0, 8'hF0, 1'b0);

    // flush in REQ before acceptance
    lsu_en = 1'b1; lsu_op = 4'b0011; lsu_addr = 64'h8000_0008;
    tick();
    lsu_en = 1'b0; flush = 1'b1;
    #1;
    check("flreq_req_valid", 64'(mem_req_valid), 64'd1);
    tick();
    flush = 1'b0;
    #1;
    check("flreq_valid_drop", 64'(mem_req_valid), 64'd0);
    check("flreq_busy",       64'(ls_valid), 64'd0);
    check("flreq_rd_data",    ls_rd_data, exp_rd);

    // flush in RSP: response still awaited, data discarded
    lsu_en = 1'b1; lsu_op = 4'b0100; lsu_addr = 64'h8000_0000;
    tick();
    lsu_en = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; flush = 1'b1;
    #1;
    check("flrsp_busy_flush", 64'(ls_valid), 64'd1);
    tick();
    flush = 1'b0;
    #1;
    check("flrsp_busy_wait", 64'(ls_valid), 64'd1);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h0000_0000_0000_00FF;
    #1;
    check("flrsp_busy_rsp", 64'(ls_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("flrsp_rd_data",   ls_rd_data, exp_rd);
    check("flrsp_req_valid", 64'(mem_req_valid), 64'd0);

    // enable with flush in IDLE is dropped
    lsu_en = 1'b1; flush = 1'b1; lsu_op = 4'b0000;
    #1;
    check("flidle_busy", 64'(ls_valid), 64'd0);
    tick();
    lsu_en = 1'b0; flush = 1'b0;
    #1;
    check("flidle_req_valid", 64'(mem_req_valid), 64'd0);

`ifdef YSYX_22051013_LSU_MISALIGN_CHECK_EN
    // misaligned lw trapped locally
    lsu_en = 1'b1; lsu_op = 4'b0010; lsu_addr = 64'h8000_0002;
    #1;
    check("mis_busy", 64'(ls_valid), 64'd0);
    tick();
    lsu_en = 1'b0;
    #1;
    check("mis_pulse",     64'(lsu_misalign), 64'd1);
    check("mis_req_valid", 64'(mem_req_valid), 64'd0);
    check("mis_rd_data",   ls_rd_data, 64'd0);
    tick();
    check("mis_pulse_end", 64'(lsu_misalign), 64'd0);
    exp_rd = 64'd0;
`else
    // misaligned sw issued as-is, upper strobes and bytes lost
    run_op("sw_mis", 4'b1010, 64'h8000_0006, 64'hAABB_CCDD, 64'd0, 0, 0,
           64'h8000_0000, 64'hCCDD_0000_0000_0000, 8'hC0, 1'b1);
`endif

    // reset in RSP, late response afterwards is ignored
    lsu_en = 1'b1; lsu_op = 4'b0011; lsu_addr = 64'h8000_0018; lsu_wdata = 64'h55;
    tick();
    lsu_en = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1122_3344_5566_7788;
    #1;
    check("rstrsp_req_valid", 64'(mem_req_valid), 64'd0);
    check("rstrsp_req_addr",  mem_req_addr, 64'd0);
    check("rstrsp_req_wstrb", 64'(mem_req_wstrb), 64'd0);
    check("rstrsp_busy",      64'(ls_valid), 64'd0);
    check("rstrsp_rd_data",   ls_rd_data, 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("rstrsp_rd_after",  ls_rd_data, 64'd0);
    check("rstrsp_valid_after", 64'(mem_req_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22051013_lsu.md
Name: ysyx_22051013_lsu

Overview:
Memory-access stage of the pipelined core. It sits between the EXU and the WBU.
- Takes the load/store command and the effective address from EXU.
- Runs one outstanding request on a valid/ready memory port.
- Aligns and sign- or zero-extends load data into a registered ls_rd_data for the WBU.
- Drives ls_valid, the LSU stall/busy flag the WBU and hazard logic consume.

Parameters:
ADDR_W, 64, memory address width
DATA_W, 64, data bus width; only 64 is supported

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lsu_en  in  1  EXU presents a memory op this cycle
lsu_op  in  4  [3] store, [2] unsigned load, [1:0] size (0=B, 1=H, 2=W, 3=D)
lsu_addr  in  ADDR_W  effective address (exu_res)
lsu_wdata  in  DATA_W  store data, right-aligned
flush  in  1  ie_flush from WBU
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  8-byte-aligned address
mem_req_wen  out  1  store request
mem_req_wdata  out  DATA_W  lane-shifted store data
mem_req_wstrb  out  8  byte strobes
mem_rsp_valid  in  1  read data / write ack
mem_rsp_rdata  in  DATA_W  raw 64-bit read data
ls_rd_data  out  DATA_W  extended load result, registered
ls_valid  out  1  LSU busy: pipeline must stall

Behaviour:
- Reset:
  - State goes to IDLE.
  - mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0, ls_rd_data=0.
  - ls_valid=0 in the reset cycle. Reset mid-transaction abandons the transaction; any late mem_rsp_valid seen in IDLE is ignored.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - If lsu_en & ~flush: register addr, op, wdata and the computed wstrb; go to REQ.
  - If lsu_en & flush: stay in IDLE.
- REQ:
  - mem_req_valid=1; request outputs are held stable until ready.
  - On mem_req_ready, go to RSP.
  - flush before acceptance drops the request and returns to IDLE; ls_rd_data is unchanged.
- RSP:
  - Wait for mem_rsp_valid, then go to IDLE.
  - On a load, register ls_rd_data on that edge.
  - flush during RSP sets a discard flag. The response is still awaited, but ls_rd_data is not updated.
- Busy flag: ls_valid = (IDLE & lsu_en & ~flush) | REQ | (RSP & ~mem_rsp_valid). It drops in the response cycle, so ls_rd_data is valid the cycle the op reaches WB.
- Minimum occupancy: 3 cycles (T enable, T+1 REQ accepted, T+2 response); ls_valid is high in T and T+1.
- Address and store lanes:
  - mem_req_addr = {addr[63:3], 3'b0}.
  - off = addr[2:0].
  - wstrb = (B:0x01, H:0x03, W:0x0F, D:0xFF) << off.
  - wdata = lsu_wdata << (8*off).
- Load extraction:
  - raw = rdata >> (8*off), truncated to the op size.
  - Unsigned ops zero-extend; signed ops sign-extend from bit 7/15/31.
  - D ignores the unsigned bit.
- Stores leave ls_rd_data unchanged.
- lsu_en asserted while the FSM is not in IDLE is ignored; the pipeline is stalled by ls_valid.

Optional Feature:
YSYX_22051013_LSU_MISALIGN_CHECK_EN
- Defined:
  - Adds output lsu_misalign (1 bit).
  - Misalignment means (H & addr[0]) | (W & addr[1:0]!=0) | (D & addr[2:0]!=0).
  - A misaligned IDLE & lsu_en issues no bus request and pulses lsu_misalign for one cycle.
  - ls_rd_data is set to 0 and ls_valid stays 0.
- Undefined: no port and no check. A misaligned access is issued as-is; strobes are truncated to 8 bits and the upper bytes are lost.

Decomposition:
- Shared define file:
  - lsu_op field positions
  - size encodings
  - state encodings
  - existing ysyx_22051013_DATA/PC width macros
- One sub-module, ysyx_22051013_lsu_ext: combinational load shift, truncate and extend (rdata, off, op -> result). Reused by any future cache bypass path.

Test Plan:
- lb signed, addr 0x80000003, rdata 0x0000_0000_8000_0000 (byte at off 3 = 0x80) -> ls_rd_data=0xFFFF_FFFF_FFFF_FF80 after response; lbu same -> 0x80.
- sh addr 0x80000006, wdata 0x1234 -> wstrb=0xC0, req_addr=0x80000000, req_wdata=0x1234_0000_0000_0000, wen=1.
- ld with ready held low 5 cycles, then response delayed 3 cycles -> req fields stable while waiting; ls_valid high every cycle until the rsp cycle, then low.
- flush in REQ before ready -> req_valid drops next cycle, FSM in IDLE, ls_rd_data unchanged. flush in RSP -> awaits rsp, ls_rd_data unchanged.
- rst asserted in RSP, then rsp_valid in the next cycle -> all outputs 0, response ignored.
- MISALIGN_CHECK_EN: lw addr 0x80000002 -> lsu_misalign pulse, no mem_req_valid, ls_rd_data=0.
